// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a raw WS2812 serial line into 24-bit pixels with frame-end and error strobes.
// Latency: valid rises 3 clk after the din falling edge that ends bit 24 (2 sync flops + 1 register).
// Backpressure: none; the line cannot be stalled, so every strobe is a single cycle and must be taken then.
module ws2812_rx #(
  parameter int NUM_LEDS = 50,
  parameter int CLK_MHZ  = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        error
);

  // Pulse-width thresholds in clk cycles, rounded up so short pulses never qualify early.
  localparam int T_MIN      = (CLK_MHZ * 150 + 999) / 1000;
  localparam int T_THRESH   = (CLK_MHZ * 625 + 999) / 1000;
  localparam int T_HIGH_MAX = (CLK_MHZ * 1500 + 999) / 1000;
  localparam int T_RESET    = CLK_MHZ * 50;

  localparam int LOW_W = $clog2(T_RESET + 1);
  // hi_cnt must hold T_HIGH_MAX+1, the value that flags a stuck-high line.
  localparam int HI_W  = $clog2(T_HIGH_MAX + 2);

  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(T_RESET - 1);
  localparam logic [HI_W-1:0]  HI_MIN   = HI_W'(T_MIN);
  localparam logic [HI_W-1:0]  HI_THR   = HI_W'(T_THRESH);
  localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(T_HIGH_MAX);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             din_m;
  logic             din_s;
  logic [LOW_W-1:0] low_cnt;
  logic [HI_W-1:0]  hi_cnt;
  logic [4:0]       bit_cnt;
  logic [7:0]       pix_cnt;
  logic [23:0]      shift;
  logic             ovf_seen;
  logic             bit_val;
  logic [23:0]      shift_nxt;

  // Long high pulses encode a one; the new bit enters at the LSB so the first bit ends up as the MSB.
  assign bit_val   = (hi_cnt >= HI_THR);
  assign shift_nxt = {shift[22:0], bit_val};

  // Two-flop synchronizer: din is asynchronous and nothing else may look at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  // Pulse-width decoder FSM with registered pixel, frame and error strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      low_cnt    <= '0;
      hi_cnt     <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      shift      <= '0;
      ovf_seen   <= 1'b0;
      rgb_data   <= '0;
      led_num    <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state)
        // Wait for a full reset gap before trusting the line again.
        SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == LOW_LAST) begin
            state    <= IDLE;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            ovf_seen <= 1'b0;
          end else begin
            low_cnt <= low_cnt + LOW_W'(1);
          end
        end
        IDLE: begin
          if (din_s) begin
            state  <= HIGH;
            hi_cnt <= HI_W'(1);
          end
        end
        HIGH: begin
          if (hi_cnt > HI_MAX) begin
            // Line stuck high: abandon the frame and resynchronize.
            error    <= 1'b1;
            state    <= SYNC;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            ovf_seen <= 1'b0;
          end else if (din_s) begin
            hi_cnt <= hi_cnt + HI_W'(1);
          end else if (hi_cnt < HI_MIN) begin
            // Too short to be a real bit: treat as a glitch.
            error    <= 1'b1;
            state    <= SYNC;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            ovf_seen <= 1'b0;
          end else begin
            shift   <= shift_nxt;
            state   <= LOW;
            low_cnt <= '0;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (32'(pix_cnt) < NUM_LEDS) begin
                rgb_data <= shift_nxt;
                led_num  <= pix_cnt;
                valid    <= 1'b1;
              end else if (!ovf_seen) begin
                // Only the first dropped pixel of a frame is reported.
                error    <= 1'b1;
                ovf_seen <= 1'b1;
              end
              if (pix_cnt != 8'hFF) begin
                pix_cnt <= pix_cnt + 8'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (din_s) begin
            state  <= HIGH;
            hi_cnt <= HI_W'(1);
          end else if (low_cnt == LOW_LAST) begin
            // Reset gap closes the frame; leftover bits mean a truncated pixel.
            frame_done <= 1'b1;
            error      <= (bit_cnt != 5'd0);
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            ovf_seen   <= 1'b0;
            state      <= IDLE;
          end else begin
            low_cnt <= low_cnt + LOW_W'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 50, is the maximum pixels accepted per frame.
REQ-002 Parameter CLK_MHZ, default 12, is the clk frequency in MHz and sets all timing constants.
REQ-003 Derived constants SHALL be: T_MIN=ceil(CLK_MHZ*150/1000), T_THRESH=ceil(CLK_MHZ*625/1000), T_HIGH_MAX=ceil(CLK_MHZ*1500/1000), T_RESET=CLK_MHZ*50. At 12 MHz these are 2, 8, 18 and 600.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port din, input, 1: raw WS2812 serial line, asynchronous to clk.
REQ-007 Port rgb_data, output, 24: last decoded pixel, MSB received first.
REQ-008 Port led_num, output, 8: index of that pixel within the frame, 0 = first pixel after the reset gap.
REQ-009 Port valid, output, 1: one-cycle strobe; rgb_data/led_num are valid in that cycle.
REQ-010 Port frame_done, output, 1: one-cycle strobe at end of frame (reset gap detected).
REQ-011 Port error, output, 1: one-cycle strobe on any protocol violation.

Function
REQ-012 din SHALL pass a 2-flop synchronizer (din_s) before any use; no other logic samples din.
REQ-013 States: SYNC, IDLE, HIGH, LOW.
REQ-014 SYNC: low_cnt increments while din_s=0 and clears while din_s=1. At low_cnt=T_RESET-1 -> IDLE, with bit_cnt=0 and pix_cnt=0.
REQ-015 IDLE: din_s=1 -> HIGH with hi_cnt=1. No timeout in IDLE.
REQ-016 HIGH: hi_cnt increments per cycle while din_s=1. hi_cnt>T_HIGH_MAX -> error pulse, -> SYNC.
REQ-017 HIGH with din_s=0 and hi_cnt<T_MIN is a glitch -> error pulse, -> SYNC.
REQ-018 HIGH with din_s=0 and hi_cnt>=T_MIN: shift bit (hi_cnt>=T_THRESH) into the 24-bit shift register LSB, bit_cnt+1, -> LOW with low_cnt=0.
REQ-019 When bit 24 is shifted in:
- if pix_cnt<NUM_LEDS: rgb_data<=shift value, led_num<=pix_cnt, valid=1 for one cycle;
- in all cases: pix_cnt+1 (saturating at 255), bit_cnt<=0.
REQ-020 Latency: valid asserts 3 clk after the falling edge of din (2 sync + 1 register).
REQ-021 LOW: din_s=1 -> HIGH with hi_cnt=1. Otherwise low_cnt increments; at low_cnt=T_RESET-1 -> frame end.
REQ-022 Frame end: frame_done=1 for one cycle. If bit_cnt!=0 (partial pixel), error=1 in the same cycle and the partial bits are discarded. bit_cnt<=0, pix_cnt<=0, -> IDLE.
REQ-023 Pixels beyond NUM_LEDS SHALL be dropped without a valid strobe. The first dropped pixel SHALL pulse error once per frame.
REQ-024 Entering SYNC from an error clears bit_cnt and pix_cnt. Decoding resumes only after a full T_RESET low gap.
REQ-025 Counter widths: low_cnt is $clog2(T_RESET+1) bits; hi_cnt saturates at T_HIGH_MAX+1; no wrap is permitted.
REQ-026 valid, frame_done and error are registered outputs and never combinational from din.

Reset
REQ-027 reset_n=0 SHALL immediately force:
- state=SYNC; low_cnt, hi_cnt, bit_cnt, pix_cnt=0;
- rgb_data=0, led_num=0, valid=0, frame_done=0, error=0;
- synchronizer flops=0.
REQ-028 Reset asserted mid-pixel discards the partial pixel with no strobe. After release, the block requires a full T_RESET low gap before decoding.

Verification (CLK_MHZ=12)
REQ-029 Power-up: din low for 600 clk, then pixel 0xFF0055 (1 = 10 clk high/5 low, 0 = 4 high/11 low), then 600 low -> valid once with rgb_data=0xFF0055, led_num=0, then frame_done once, error never.
REQ-030 Three pixels 0x000001, 0x800000, 0x123456 back-to-back -> three valid strobes with led_num 0, 1, 2 and the matching data, then one frame_done.
REQ-031 Glitch: 1-clk high pulse mid-pixel -> error once, no valid. The next frame after a 600-clk gap decodes correctly with led_num starting at 0.
REQ-032 Stuck high: din high for 20 clk -> error once, state SYNC, no valid.
REQ-033 Overflow, NUM_LEDS=2: send 3 pixels -> 2 valid strobes, error once, then frame_done.
REQ-034 Partial pixel: 12 bits then a 600-clk low gap -> frame_done and error in the same cycle, no valid. reset_n pulsed mid-pixel -> all outputs 0 and no valid.
